// File: rtl/plain_broadcast_collect.sv
// Iteration sequencer and result packer behind compute_plain_broadcast: walks every (e, d) pair,
// captures alpha/beta on the stage's done and writes them word-serially into the broadcast buffer.
module plain_broadcast_collect #(
  parameter string       PARAMETER_SET = "L1",
  parameter int unsigned TAU           = 17,
  parameter int unsigned D_SPLIT       = (PARAMETER_SET == "L1") ? 1 : 2,
  parameter int unsigned T             = (PARAMETER_SET == "L5") ? 4 : 3,
  parameter int unsigned WIDTH         = 32,
  localparam int unsigned OUT_DEPTH    = TAU * D_SPLIT * 2 * T,
  localparam int unsigned E_W          = (TAU > 1) ? $clog2(TAU) : 1,
  localparam int unsigned D_W          = (D_SPLIT > 1) ? $clog2(D_SPLIT) : 1,
  localparam int unsigned A_W          = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_start_cpb,
  input  logic                 i_done_cpb,
  input  logic [WIDTH*T-1:0]   i_alpha,
  input  logic [WIDTH*T-1:0]   i_beta,
  output logic [E_W-1:0]       o_iter_e,
  output logic [D_W-1:0]       o_iter_d,
  output logic                 o_wr_en,
  output logic [A_W-1:0]       o_wr_addr,
  output logic [WIDTH-1:0]     o_wr_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned J_W  = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned SH_W = 2 * T * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_WR_A, S_WR_B, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [E_W-1:0]   e_d;
  logic [D_W-1:0]   d_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             start_d, wr_en_d, done_d, busy_d;
  logic [A_W-1:0]   addr_d;
  logic [WIDTH-1:0] data_d;
  logic [A_W-1:0]   base_addr;
  logic             last_j, d_more, e_more;

  // First buffer word of the current iteration; iterations pack contiguously.
  assign base_addr = A_W'((32'(o_iter_e) * D_SPLIT + 32'(o_iter_d)) * 2 * T);
  assign last_j    = (j_q == J_W'(T - 1));
  assign d_more    = (32'(o_iter_d) + 32'd1) < D_SPLIT;
  assign e_more    = (32'(o_iter_e) + 32'd1) < TAU;

  // Next-state and next-output decode; outputs are registered so they line up with the state.
  always_comb begin
    state_d = state_q;
    e_d     = o_iter_e;
    d_d     = o_iter_d;
    j_d     = j_q;
    sh_d    = sh_q;
    start_d = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = o_wr_addr;
    data_d  = o_wr_data;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_START;
          start_d = 1'b1;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_done_cpb) begin
          state_d = S_WR_A;
          j_d     = '0;
          wr_en_d = 1'b1;
          addr_d  = base_addr;
          data_d  = i_alpha[WIDTH*T-1 -: WIDTH];
          sh_d    = {i_alpha, i_beta} << WIDTH;
        end
      end
      S_WR_A: begin
        // Alpha's last word is followed directly by beta's first; the shifter holds both.
        wr_en_d = 1'b1;
        addr_d  = o_wr_addr + A_W'(1);
        data_d  = sh_q[SH_W-1 -: WIDTH];
        sh_d    = sh_q << WIDTH;
        if (last_j) begin
          state_d = S_WR_B;
          j_d     = '0;
        end else begin
          j_d = j_q + J_W'(1);
        end
      end
      S_WR_B: begin
        if (last_j) begin
          state_d = S_NEXT;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = o_wr_addr + A_W'(1);
          data_d  = sh_q[SH_W-1 -: WIDTH];
          sh_d    = sh_q << WIDTH;
          j_d     = j_q + J_W'(1);
        end
      end
      S_NEXT: begin
        if (d_more) begin
          d_d     = o_iter_d + D_W'(1);
          state_d = S_START;
          start_d = 1'b1;
        end else if (e_more) begin
          d_d     = '0;
          e_d     = o_iter_e + E_W'(1);
          state_d = S_START;
          start_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        e_d     = '0;
        d_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters, capture shifter and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      sh_q        <= '0;
      o_iter_e    <= '0;
      o_iter_d    <= '0;
      o_start_cpb <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      sh_q        <= sh_d;
      o_iter_e    <= e_d;
      o_iter_d    <= d_d;
      o_start_cpb <= start_d;
      o_wr_en     <= wr_en_d;
      o_wr_addr   <= addr_d;
      o_wr_data   <= data_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_plain_broadcast_collect.sv
// Bench for plain_broadcast_collect: L1, L3 and L5 instances, a stage responder, and a
// buffer-level model checked every cycle plus literal expectations.
module tb_plain_broadcast_collect;

  logic         clk;
  logic         rst [3];
  logic         st [3];
  logic         dcpb [3];
  logic [127:0] alpha [3];
  logic [127:0] beta [3];
  logic         st_o [3];
  logic         wr [3];
  logic         busy [3];
  logic         dn [3];
  logic         id [3];
  logic [4:0]   ie [3];
  logic [8:0]   addr [3];
  logic [31:0]  data [3];

  int vecs = 0;
  int errs = 0;
  int hold_k = -1;
  int hold_n = -1;
  int stray_n [3];

  // model state (owned by the compare process)
  int          wc [3];
  int          sc [3];
  int          since_wr [3];
  int          done_cnt [3];
  int          last_addr [3];
  bit          running [3];
  int          wcnt [3][272];
  logic [31:0] mem [3][272];

  // responder state
  int cnt [3];
  int rn [3];
  int stray [3];
  int le [3];
  int ld [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned TG = (g == 2) ? 4 : 3;
    localparam int unsigned DG = (g == 0) ? 1 : 2;
    localparam int unsigned AW = $clog2(17 * DG * 2 * TG);
    logic [AW-1:0] a_loc;
    plain_broadcast_collect #(.TAU(17), .D_SPLIT(DG), .T(TG)) u_dut (
      .i_clk(clk), .i_rst(rst[g]), .i_start(st[g]), .o_start_cpb(st_o[g]),
      .i_done_cpb(dcpb[g]), .i_alpha(alpha[g][32*TG-1:0]), .i_beta(beta[g][32*TG-1:0]),
      .o_iter_e(ie[g]), .o_iter_d(id[g]), .o_wr_en(wr[g]), .o_wr_addr(a_loc),
      .o_wr_data(data[g]), .o_busy(busy[g]), .o_done(dn[g])
    );
    assign addr[g] = 9'(a_loc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tk(int k); return (k == 2) ? 4 : 3; endfunction
  function automatic int dk(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int depth_of(int k); return 17 * dk(k) * 2 * tk(k); endfunction

  // Word idx (0..2T-1, alpha then beta, MS word first) that iteration (e,d) hands back.
  function automatic logic [31:0] wv(int k, int e, int d, int idx);
    int t;
    t = tk(k);
    if (k == 0 && e == 0 && d == 0) begin
      case (idx)
        0: return 32'h11111111;
        1: return 32'h22222222;
        2: return 32'h33333333;
        3: return 32'hAAAAAAAA;
        4: return 32'hBBBBBBBB;
        default: return 32'hCCCCCCCC;
      endcase
    end
    return ((idx < t) ? 32'hA000_0000 : 32'hB000_0000) + 32'(e << 16) + 32'(d << 8) + 32'(idx % t);
  endfunction

  function automatic logic [127:0] build(int k, int e, int d, int half);
    logic [127:0] v;
    int t;
    t = tk(k);
    v = '0;
    for (int j = 0; j < t; j++) v[32*t-1-32*j -: 32] = wv(k, e, d, half * t + j);
    return v;
  endfunction

  task automatic check(input int k, input string nm, input longint unsigned got,
                       input longint unsigned exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", nm, k, got, exp);
    end
  endtask

  // Stage responder: done LAT cycles after each start; operands are junk except in the done cycle.
  initial begin
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; rn[k] = 0; stray[k] = 0; le[k] = 0; ld[k] = 0;
      dcpb[k] = 1'b0; alpha[k] = '0; beta[k] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (!rst[k]) begin
          cnt[k] = 0; rn[k] = 0; stray[k] = 0;
          dcpb[k] = 1'b0; alpha[k] = '0; beta[k] = '0;
        end else begin
          dcpb[k] = 1'b0;
          if (st_o[k]) begin
            cnt[k] = (hold_k == k && hold_n == rn[k]) ? 200 : 4;
            le[k] = int'(ie[k]);
            ld[k] = int'(id[k]);
          end
          alpha[k] = ~build(k, le[k], ld[k], 0);
          beta[k]  = ~build(k, le[k], ld[k], 1);
          if (!st_o[k] && cnt[k] > 0) begin
            cnt[k]--;
            if (cnt[k] == 0) begin
              dcpb[k]  = 1'b1;
              alpha[k] = build(k, le[k], ld[k], 0);
              beta[k]  = build(k, le[k], ld[k], 1);
              stray[k] = (stray_n[k] == rn[k]) ? 2 : 0;
              rn[k]++;
            end
          end else if (!st_o[k] && stray[k] > 0) begin
            stray[k]--;
            if (stray[k] == 0) dcpb[k] = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: buffer-level model of every start, write, busy and done.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int t2, dd, n, idx;
      t2 = 2 * tk(k);
      dd = dk(k);
      if (!rst[k]) begin
        check(k, "reset_outs", 64'({st_o[k], wr[k], dn[k], busy[k], ie[k], id[k], addr[k], data[k]}), 64'd0);
        running[k] = 1'b0;
        wc[k] = 0; sc[k] = 0; since_wr[k] = 100; done_cnt[k] = 0; last_addr[k] = -1;
        for (int a = 0; a < 272; a++) wcnt[k][a] = 0;
      end else begin
        check(k, "busy", 64'(busy[k]), 64'(running[k]));
        if (!running[k]) check(k, "idle_quiet", 64'({st_o[k], wr[k], dn[k]}), 64'd0);
        if (st_o[k]) begin
          check(k, "start_gap", 64'(wc[k]), 64'(sc[k] * t2));
          check(k, "start_iter", 64'({ie[k], id[k]}), 64'(((sc[k] / dd) << 1) | (sc[k] % dd)));
          sc[k]++;
        end
        if (wr[k]) begin
          n = wc[k] / t2;
          idx = wc[k] % t2;
          check(k, "wr_addr", 64'(addr[k]), 64'(wc[k]));
          check(k, "wr_data", 64'(data[k]), 64'(wv(k, n / dd, n % dd, idx)));
          check(k, "wr_iter", 64'({ie[k], id[k]}), 64'(((n / dd) << 1) | (n % dd)));
          if (int'(addr[k]) < depth_of(k)) begin
            mem[k][addr[k]] = data[k];
            wcnt[k][addr[k]]++;
          end
          last_addr[k] = int'(addr[k]);
          wc[k]++;
          since_wr[k] = 0;
        end else begin
          since_wr[k]++;
        end
        if (dn[k]) begin
          check(k, "done_counts", 64'({16'(wc[k]), 16'(sc[k])}), 64'({16'(depth_of(k)), 16'(17 * dd)}));
          check(k, "done_lat", 64'(since_wr[k]), 64'd2);
          done_cnt[k]++;
          running[k] = 1'b0;
        end else if (st[k] && !running[k]) begin
          running[k] = 1'b1;
          wc[k] = 0; sc[k] = 0; done_cnt[k] = 0; last_addr[k] = -1;
          for (int a = 0; a < 272; a++) wcnt[k][a] = 0;
        end
      end
    end
  end

  task automatic pulse(input int k);
    @(posedge clk); #2 st[k] = 1'b1;
    @(posedge clk); #2 st[k] = 1'b0;
  endtask

  // Returns in the cycle of the n-th (0-based) start pulse counted from the call.
  task automatic wait_start(input int k, input int n);
    int seen;
    bit ok;
    seen = 0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #2;
      if (st_o[k]) begin
        if (seen == n) begin ok = 1'b1; break; end
        seen++;
      end
    end
    check(k, "start_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #2;
      if (dn[k]) begin ok = 1'b1; break; end
    end
    check(k, "done_seen", 64'(ok), 64'd1);
    @(negedge clk); #1;
  endtask

  task automatic post_checks(input int k);
    int bad;
    bad = 0;
    for (int a = 0; a < depth_of(k); a++) if (wcnt[k][a] != 1) bad++;
    check(k, "addr_once", 64'(bad), 64'd0);
    check(k, "one_done", 64'(done_cnt[k]), 64'd1);
    check(k, "last_addr", 64'(last_addr[k]), 64'(depth_of(k) - 1));
  endtask

  task automatic l1_literals();
    check(0, "lit_a0", 64'(mem[0][0]), 64'h11111111);
    check(0, "lit_a1", 64'(mem[0][1]), 64'h22222222);
    check(0, "lit_a2", 64'(mem[0][2]), 64'h33333333);
    check(0, "lit_b0", 64'(mem[0][3]), 64'hAAAAAAAA);
    check(0, "lit_b1", 64'(mem[0][4]), 64'hBBBBBBBB);
    check(0, "lit_b2", 64'(mem[0][5]), 64'hCCCCCCCC);
    check(0, "lit_101", 64'(mem[0][101]), 64'hB0100002);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; st[k] = 1'b0; stray_n[k] = -1;
    end
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;

    // L1 run with stray i_start in S_WAIT / S_WR_B and a stray done in S_WR_A.
    stray_n[0] = 3;
    pulse(0);
    wait_start(0, 2);
    @(posedge clk); #2 st[0] = 1'b1;
    @(posedge clk); #2 st[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2 st[0] = 1'b1;
    @(posedge clk); #2 st[0] = 1'b0;
    wait_done(0);
    post_checks(0);
    l1_literals();
    stray_n[0] = -1;

    // Abort during S_WR_B of iteration 5, then a full restart with a long S_WAIT.
    pulse(0);
    wait_start(0, 5);
    repeat (9) @(posedge clk);
    #2 rst[0] = 1'b0;
    #1;
    check(0, "abort_now", 64'({wr[0], busy[0], dn[0]}), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst[0] = 1'b1;
    repeat (10) @(posedge clk);
    hold_k = 0;
    hold_n = 1;
    pulse(0);
    wait_done(0);
    post_checks(0);
    l1_literals();
    hold_k = -1;

    // L3: two splits per repetition.
    pulse(1);
    wait_done(1);
    post_checks(1);
    check(1, "lit_e1d1_0", 64'(mem[1][18]), 64'hA0010100);
    check(1, "lit_e1d1_1", 64'(mem[1][19]), 64'hA0010101);
    check(1, "lit_e1d1_2", 64'(mem[1][20]), 64'hA0010102);

    // L5: four words per half, stride 8.
    pulse(2);
    wait_done(2);
    post_checks(2);
    check(2, "lit_8", 64'(mem[2][8]), 64'hA0000100);
    check(2, "lit_271", 64'(mem[2][271]), 64'hB0100103);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
